// File: rtl/exibe_pkg.sv
// Shared state codes, timing defaults and helpers for the LED sequence display.
package exibe_pkg;

  localparam int unsigned T_ACESO_DEF   = 4;
  localparam int unsigned T_APAGADO_DEF = 2;
  localparam int unsigned TIMER_W       = 16;

  typedef enum logic [3:0] {
    ST_INICIAL    = 4'h0,
    ST_PREPARACAO = 4'h1,
    ST_CARREGA    = 4'h2,
    ST_ACENDE     = 4'h3,
    ST_APAGA      = 4'h4,
    ST_PROXIMO    = 4'h5,
    ST_FINAL      = 4'hF
  } estado_t;

  // Code reported on db_estado when the state register holds an undefined value.
  localparam logic [3:0] DB_INVALIDO = 4'h3;

  function automatic logic estado_legal(input logic [3:0] codigo);
    case (codigo)
      4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h5, 4'hF: estado_legal = 1'b1;
      default:                                  estado_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/exibe_sequencia_if.sv
// Bus between the sequence display and its player-side logic and memory.
interface exibe_sequencia_if;
  // iniciar is a level: it is only looked at while idle (inicial), and a held
  // level restarts the sequence; there is no valid/ready handshake on this bus.
  logic       iniciar;
  logic [3:0] limite;
  logic [3:0] dado_mem;
  logic [3:0] endereco;
  logic [3:0] leds;
  logic       ativo;
  logic       pronto;
  logic [3:0] db_estado;

  modport master (
    output iniciar, limite, dado_mem,
    input  endereco, leds, ativo, pronto, db_estado
  );

  modport slave (
    input  iniciar, limite, dado_mem,
    output endereco, leds, ativo, pronto, db_estado
  );
endinterface

// File: rtl/contador_timer.sv
// Free-running up counter with synchronous clear (zera wins over conta).
module contador_timer #(
  parameter int unsigned W = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         zera,
  input  logic         conta,
  output logic [W-1:0] valor
);

  logic [W-1:0] valor_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valor_q <= '0;
    end else if (zera) begin
      valor_q <= '0;
    end else if (conta) begin
      valor_q <= valor_q + 1'b1;
    end
  end

  assign valor = valor_q;

endmodule

// File: rtl/exibe_sequencia.sv
// Shows memory entries 0..limite on the LEDs, each lit T_ACESO cycles then dark T_APAGADO.
// Optional macro EXIBE_PAUSA_EN adds a pausa input that freezes the lit/dark phases.
module exibe_sequencia
  import exibe_pkg::*;
#(
  parameter int unsigned T_ACESO   = T_ACESO_DEF,
  parameter int unsigned T_APAGADO = T_APAGADO_DEF
) (
  input  logic               clock,
  input  logic               reset,
`ifdef EXIBE_PAUSA_EN
  input  logic               pausa,
`endif
  exibe_sequencia_if.slave   bus
);

  localparam logic [TIMER_W-1:0] FIM_ACESO   = TIMER_W'(T_ACESO - 1);
  localparam logic [TIMER_W-1:0] FIM_APAGADO = TIMER_W'(T_APAGADO - 1);

  estado_t            estado_q, estado_d;
  logic [3:0]         end_q, end_d;
  logic [3:0]         led_q, led_d;
  logic               zera, conta, pausado;
  logic [TIMER_W-1:0] timer;

`ifdef EXIBE_PAUSA_EN
  assign pausado = pausa;
`else
  assign pausado = 1'b0;
`endif

  contador_timer #(.W(TIMER_W)) u_timer (
    .clock (clock),
    .reset (reset),
    .zera  (zera),
    .conta (conta),
    .valor (timer)
  );

  always_comb begin
    estado_d = estado_q;
    end_d    = end_q;
    led_d    = led_q;
    zera     = 1'b0;
    conta    = 1'b0;
    case (estado_q)
      ST_INICIAL: begin
        if (bus.iniciar) estado_d = ST_PREPARACAO;
      end
      ST_PREPARACAO: begin
        end_d    = '0;
        zera     = 1'b1;
        estado_d = ST_CARREGA;
      end
      ST_CARREGA: begin
        led_d    = bus.dado_mem;
        zera     = 1'b1;
        estado_d = ST_ACENDE;
      end
      ST_ACENDE: begin
        if (!pausado) begin
          if (timer == FIM_ACESO) begin
            zera     = 1'b1;
            estado_d = ST_APAGA;
          end else begin
            conta = 1'b1;
          end
        end
      end
      ST_APAGA: begin
        if (!pausado) begin
          conta = 1'b1;
          if (timer == FIM_APAGADO) estado_d = ST_PROXIMO;
        end
      end
      ST_PROXIMO: begin
        // limite is compared only here, so a mid-sequence change lands at the next entry boundary.
        if (end_q == bus.limite) begin
          estado_d = ST_FINAL;
        end else begin
          end_d    = end_q + 4'd1;
          estado_d = ST_CARREGA;
        end
      end
      ST_FINAL: begin
        estado_d = ST_INICIAL;
      end
      default: begin
        estado_d = ST_INICIAL;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado_q <= ST_INICIAL;
      end_q    <= '0;
      led_q    <= '0;
    end else begin
      estado_q <= estado_d;
      end_q    <= end_d;
      led_q    <= led_d;
    end
  end

  // Outputs are pure decodes of registers, so they change only on clock or reset.
  assign bus.endereco  = end_q;
  assign bus.leds      = (estado_q == ST_ACENDE) ? led_q : 4'd0;
  assign bus.ativo     = (estado_q != ST_INICIAL);
  assign bus.pronto    = (estado_q == ST_FINAL);
  assign bus.db_estado = estado_legal(estado_q) ? estado_q : DB_INVALIDO;

endmodule

// File: tb/tb_exibe_sequencia.sv
// Directed bench for exibe_sequencia at default timing (4 lit, 2 dark cycles per entry).
module tb_exibe_sequencia;

  localparam int P = 4 + 2 + 2;

  logic       clock;
  logic       reset;
  logic [3:0] mem [16];
  logic [3:0] exp_q [$];
  int         n_vec;
  int         n_err;
`ifdef EXIBE_PAUSA_EN
  logic       pausa;
`endif

  exibe_sequencia_if bus ();

  assign bus.dado_mem = mem[bus.endereco];

  exibe_sequencia dut (
    .clock (clock),
    .reset (reset),
`ifdef EXIBE_PAUSA_EN
    .pausa (pausa),
`endif
    .bus   (bus)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Expected behaviour of cycle j after the edge that samples iniciar, n entries long.
  function automatic logic [3:0] exp_estado(input int j, input int n);
    if (j == 0) return 4'h1;
    if (j == 1 + n * P) return 4'hF;
    if (j > 1 + n * P) return 4'h0;
    case ((j - 1) % P)
      0:          return 4'h2;
      1, 2, 3, 4: return 4'h3;
      5, 6:       return 4'h4;
      default:    return 4'h5;
    endcase
  endfunction

  function automatic logic [3:0] exp_leds(input int j, input int n);
    if (exp_estado(j, n) == 4'h3) return exp_q[(j - 1) / P];
    return 4'h0;
  endfunction

  function automatic logic [3:0] exp_end(input int j, input int n);
    if (j <= n * P) return 4'((j - 1) / P);
    return 4'(n - 1);
  endfunction

  task automatic load_mem(input logic [3:0] vals [16], input int n);
    exp_q = {};
    for (int i = 0; i < 16; i++) mem[i] = vals[i];
    for (int i = 0; i < n; i++) exp_q.push_back(vals[i]);
  endtask

  task automatic test_reset();
    #2;
    n_vec++; if (bus.db_estado !== 4'h0) begin n_err++; $display("FAIL reset_db obtido %h esperado 0", bus.db_estado); end
    n_vec++; if (bus.leds !== 4'h0) begin n_err++; $display("FAIL reset_leds obtido %h esperado 0", bus.leds); end
    n_vec++; if (bus.ativo !== 1'b0 || bus.pronto !== 1'b0) begin n_err++; $display("FAIL reset_flags obtido %b%b esperado 00", bus.ativo, bus.pronto); end
    n_vec++; if (bus.endereco !== 4'h0) begin n_err++; $display("FAIL reset_end obtido %h esperado 0", bus.endereco); end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      n_vec++; if (bus.db_estado !== 4'h0) begin n_err++; $display("FAIL idle_db ciclo %0d obtido %h esperado 0", i, bus.db_estado); end
    end
  endtask

  task automatic test_sequence(input string nome, input int n);
    logic [3:0] e;
    bus.limite  = 4'(n - 1);
    bus.iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.iniciar = 1'b0;
    for (int j = 0; j < n * P + 3; j++) begin
      if (j > 0) @(negedge clock);
      e = exp_estado(j, n);
      n_vec++; if (bus.db_estado !== e) begin n_err++; $display("FAIL %s db ciclo %0d obtido %h esperado %h", nome, j, bus.db_estado, e); end
      n_vec++; if (bus.leds !== exp_leds(j, n)) begin n_err++; $display("FAIL %s leds ciclo %0d obtido %h esperado %h", nome, j, bus.leds, exp_leds(j, n)); end
      n_vec++; if (bus.pronto !== (e == 4'hF)) begin n_err++; $display("FAIL %s pronto ciclo %0d obtido %b esperado %b", nome, j, bus.pronto, e == 4'hF); end
      n_vec++; if (bus.ativo !== (e != 4'h0)) begin n_err++; $display("FAIL %s ativo ciclo %0d obtido %b esperado %b", nome, j, bus.ativo, e != 4'h0); end
      if (j > 0) begin
        n_vec++; if (bus.endereco !== exp_end(j, n)) begin n_err++; $display("FAIL %s end ciclo %0d obtido %h esperado %h", nome, j, bus.endereco, exp_end(j, n)); end
      end
    end
  endtask

  task automatic test_reset_mid();
    bus.limite  = 4'd2;
    bus.iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.iniciar = 1'b0;
    repeat (11) @(negedge clock);
    n_vec++; if (bus.leds !== 4'h6) begin n_err++; $display("FAIL mid_pre_leds obtido %h esperado 6", bus.leds); end
    reset = 1'b1;
    #1;
    n_vec++; if (bus.leds !== 4'h0) begin n_err++; $display("FAIL mid_leds obtido %h esperado 0", bus.leds); end
    n_vec++; if (bus.db_estado !== 4'h0) begin n_err++; $display("FAIL mid_db obtido %h esperado 0", bus.db_estado); end
    n_vec++; if (bus.ativo !== 1'b0) begin n_err++; $display("FAIL mid_ativo obtido %b esperado 0", bus.ativo); end
    n_vec++; if (bus.endereco !== 4'h0) begin n_err++; $display("FAIL mid_end obtido %h esperado 0", bus.endereco); end
    @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      n_vec++; if (bus.db_estado !== 4'h0) begin n_err++; $display("FAIL mid_idle ciclo %0d obtido %h esperado 0", i, bus.db_estado); end
    end
  endtask

  task automatic test_iniciar();
    int n, jj, len;
    logic [3:0] e;
    n = 2;
    len = n * P + 3;
    bus.limite  = 4'(n - 1);
    bus.iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    for (int j = 0; j < 2 * len; j++) begin
      if (j > 0) @(negedge clock);
      jj = (j < len) ? j : j - len;
      e = exp_estado(jj, n);
      n_vec++; if (bus.db_estado !== e) begin n_err++; $display("FAIL iniciar db ciclo %0d obtido %h esperado %h", j, bus.db_estado, e); end
      n_vec++; if (bus.leds !== exp_leds(jj, n)) begin n_err++; $display("FAIL iniciar leds ciclo %0d obtido %h esperado %h", j, bus.leds, exp_leds(jj, n)); end
      n_vec++; if (bus.pronto !== (e == 4'hF)) begin n_err++; $display("FAIL iniciar pronto ciclo %0d obtido %b esperado %b", j, bus.pronto, e == 4'hF); end
      if (jj > 0) begin
        n_vec++; if (bus.endereco !== exp_end(jj, n)) begin n_err++; $display("FAIL iniciar end ciclo %0d obtido %h esperado %h", j, bus.endereco, exp_end(jj, n)); end
      end
      if (j == 0 || j >= len) bus.iniciar = 1'b0;
      else if (j >= n * P) bus.iniciar = 1'b1;
      else bus.iniciar = j[0];
    end
  endtask

`ifdef EXIBE_PAUSA_EN
  task automatic test_pausa();
    int n, jj;
    logic [3:0] e;
    n = 3;
    bus.limite  = 4'(n - 1);
    bus.iniciar = 1'b1;
    @(posedge clock);
    @(negedge clock);
    bus.iniciar = 1'b0;
    for (int j = 0; j < n * P + 13; j++) begin
      if (j > 0) @(negedge clock);
      jj = (j < 3) ? j : ((j <= 13) ? 3 : j - 10);
      e = exp_estado(jj, n);
      n_vec++; if (bus.db_estado !== e) begin n_err++; $display("FAIL pausa db ciclo %0d obtido %h esperado %h", j, bus.db_estado, e); end
      n_vec++; if (bus.leds !== exp_leds(jj, n)) begin n_err++; $display("FAIL pausa leds ciclo %0d obtido %h esperado %h", j, bus.leds, exp_leds(jj, n)); end
      n_vec++; if (bus.pronto !== (e == 4'hF)) begin n_err++; $display("FAIL pausa pronto ciclo %0d obtido %b esperado %b", j, bus.pronto, e == 4'hF); end
      pausa = (j >= 3 && j <= 12);
    end
    pausa = 1'b0;
  endtask
`endif

  initial begin
    logic [3:0] v [16];
    n_vec = 0;
    n_err = 0;
    reset = 1'b1;
    bus.iniciar = 1'b0;
    bus.limite  = 4'd0;
    for (int i = 0; i < 16; i++) mem[i] = 4'd0;
`ifdef EXIBE_PAUSA_EN
    pausa = 1'b0;
`endif
    test_reset();

    for (int i = 0; i < 16; i++) v[i] = 4'd0;
    v[0] = 4'd1; v[1] = 4'd2; v[2] = 4'd4;
    load_mem(v, 3);
    test_sequence("tres", 3);

    v[0] = 4'd8;
    load_mem(v, 1);
    test_sequence("unico", 1);

    for (int i = 0; i < 16; i++) v[i] = 4'(i);
    load_mem(v, 16);
    test_sequence("completo", 16);

    v[0] = 4'd5; v[1] = 4'd6; v[2] = 4'd7;
    load_mem(v, 3);
    test_reset_mid();
    test_sequence("pos_reset", 3);

    v[0] = 4'd9; v[1] = 4'd3;
    load_mem(v, 2);
    test_iniciar();

`ifdef EXIBE_PAUSA_EN
    v[0] = 4'd1; v[1] = 4'd2; v[2] = 4'd4;
    load_mem(v, 3);
    test_pausa();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/exibe_sequencia.md
EXIBE_SEQUENCIA -- requirements
Module: exibe_sequencia

Interface
REQ-001 Parameter T_ACESO, default 4: cycles each LED value is shown (legal range 1..65535).
REQ-002 Parameter T_APAGADO, default 2: cycles LEDs are dark between values (legal range 1..65535).
REQ-003 The block SHALL have these ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- iniciar  in  1  start request, level-sampled in inicial.
- limite  in  4  index of the last memory entry shown; N = limite+1 entries.
- dado_mem  in  4  memory read data for endereco (asynchronous read).
- endereco  out  4  memory address being shown.
- leds  out  4  value presented to the player.
- ativo  out  1  high in every state except inicial.
- pronto  out  1  one-cycle pulse at end of sequence.
- db_estado  out  4  current state code.

Function
REQ-004 The states SHALL use these db_estado codes: inicial 0, preparacao 1, carrega 2, acende 3, apaga 4, proximo 5, final F; any other state code SHALL show 3 and return to inicial on the next cycle.
REQ-005 inicial SHALL go to preparacao when iniciar=1, else stay in inicial.
REQ-006 preparacao SHALL clear endereco and the timer, then go to carrega (1 cycle).
REQ-007 carrega SHALL register dado_mem into the LED register, clear the timer, then go to acende (1 cycle).
REQ-008 acende SHALL drive leds from the LED register and increment the timer each cycle, going to apaga (with timer cleared) in the cycle where timer == T_ACESO-1.
REQ-009 apaga SHALL drive leds=0 and increment the timer, going to proximo in the cycle where timer == T_APAGADO-1.
REQ-010 proximo SHALL go to final if endereco == limite, else increment endereco and go to carrega.
REQ-011 final SHALL assert pronto for exactly one cycle, then go to inicial.
REQ-012 leds SHALL be 0 in every state except acende.
REQ-013 The timer SHALL be 16 bits and SHALL never wrap within legal parameter values.
REQ-014 endereco SHALL never wrap: limite=15 shows addresses 0..15, then final.
REQ-015 iniciar SHALL be ignored outside inicial; a held iniciar SHALL restart the sequence after final→inicial.
REQ-016 limite SHALL be sampled in proximo only; a change mid-sequence takes effect at the next comparison.
REQ-017 Latency: with iniciar sampled at edge k, the first acende cycle SHALL begin at edge k+2, and pronto SHALL be high in cycle k+1+N*(T_ACESO+T_APAGADO+2).

Reset
REQ-018 Reset SHALL force inicial asynchronously, from any state including mid-sequence.
REQ-019 During reset: endereco=0, leds=0, timer=0, LED register=0, ativo=0, pronto=0, db_estado=0.
REQ-020 After reset release the block SHALL wait for iniciar; no partial sequence resumes.

Configuration
REQ-021 Macro EXIBE_PAUSA_EN: when defined, the block SHALL add port pausa (in, 1).
- pausa=1 in acende or apaga: the timer and the state SHALL hold, and leds SHALL keep the value for that state.
- pausa SHALL have no effect in other states.
REQ-022 When EXIBE_PAUSA_EN is undefined, the pausa port SHALL be absent and timing SHALL be exactly as REQ-017.

Structure
REQ-023 The state code constants and the T_ACESO/T_APAGADO defaults SHALL reside in a shared package, exibe_pkg.
REQ-024 The timer SHALL be one sub-module, contador_timer, with a 16-bit width and inputs zera and conta.
REQ-025 The FSM and the endereco/LED registers SHALL reside in exibe_sequencia.

Verification
REQ-026 Bench scenarios (defaults T_ACESO=4, T_APAGADO=2):
- Scenario 1: limite=2, memory {1,2,4}, iniciar pulse → leds shows 1,2,4, each for 4 cycles with 2 dark cycles between; pronto pulses once, 25 cycles after iniciar.
- Scenario 2: limite=0, memory[0]=8 → a single 8 shown for 4 cycles; pronto 9 cycles after iniciar; endereco stays 0.
- Scenario 3: limite=15, memory[i]=i → addresses 0..15 each shown once, no wrap to 0 before final; pronto after 1+16*8 cycles.
- Scenario 4: reset asserted during acende of entry 1 → leds=0, db_estado=0, ativo=0 immediately; next iniciar restarts at endereco 0.
- Scenario 5: iniciar toggled during a sequence → no effect on the sequence; iniciar held high → a new sequence starts at the cycle after final→inicial.
- Scenario 6 (EXIBE_PAUSA_EN): pausa=1 for 10 cycles mid-acende → leds holds its value, and pronto is delayed by exactly 10 cycles.
